// File: rtl/reg_file_sb_if.sv
// Purpose: decode/writeback-facing bundle of the register file (reads, two write ports, traps, allocation).
// Latency: pure wiring; no timing of its own.
// Backpressure: none; every request is accepted in the cycle it is presented.
// Ports: master = decode/writeback side; slave = register file.
interface reg_file_sb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic                         interrupt;
  logic                         exception;
  logic [DATA_W-1:0]            PC;
  logic [NUM_READ*ADDR_W-1:0]   raddr;
  logic [NUM_READ*DATA_W-1:0]   rdata;
  logic [NUM_READ-1:0]          rbusy;
  logic                         we0;
  logic [ADDR_W-1:0]            waddr0;
  logic [DATA_W-1:0]            wdata0;
  logic                         we1;
  logic [ADDR_W-1:0]            waddr1;
  logic [DATA_W-1:0]            wdata1;
  logic                         alloc_en;
  logic [ADDR_W-1:0]            alloc_addr;
  logic [DEPTH-1:0]             busy_vec;

  modport master (
    output interrupt, exception, PC, raddr,
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output alloc_en, alloc_addr,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  interrupt, exception, PC, raddr,
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  alloc_en, alloc_addr,
    output rdata, rbusy, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Purpose: GPR file with NUM_READ combinational reads, two write ports, trap EPC capture and busy scoreboard.
// Latency: reads are combinational (optional write-through bypass); writes and scoreboard updates land 1 cycle later.
// Backpressure: none; all writes, allocations and traps are accepted every cycle.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries reads, writes, trap inputs,
//        allocation and the busy_vec/rbusy scoreboard outputs.
module reg_file_sb #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 5,
  parameter int                 NUM_READ  = 2,
  parameter int                 SP_INDEX  = 29,
  parameter logic [DATA_W-1:0]  SP_RESET  = 32'h0000_0800,
  parameter int                 EPC_INDEX = 26,
  parameter int                 FWD_EN    = 1
) (
  input logic          clk,
  input logic          reset,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] EPC_A = ADDR_W'(EPC_INDEX);

  logic [DATA_W-1:0]         rf [DEPTH];
  logic [DEPTH-1:0]          busy;
  logic [DEPTH-1:0]          busy_nxt;
  logic [NUM_READ*DATA_W-1:0] rdata_c;
  logic [NUM_READ-1:0]       rbusy_c;

  logic trap;
  logic wr0;
  logic wr1;
  logic alloc;

  assign trap  = bus.interrupt | bus.exception;
  // Writes to register 0 never commit, so r0 stays zero in the array.
  assign wr0   = bus.we0 && (bus.waddr0 != '0);
  assign wr1   = bus.we1 && (bus.waddr1 != '0);
  assign alloc = bus.alloc_en && (bus.alloc_addr != '0);

  // Scoreboard next state: a trap flushes everything; otherwise commits
  // clear, and allocation is applied last so a new producer supersedes
  // a commit to the same register in the same cycle.
  always_comb begin
    busy_nxt = busy;
    if (trap) begin
      busy_nxt = '0;
    end else begin
      if (wr0)   busy_nxt[bus.waddr0]     = 1'b0;
      if (wr1)   busy_nxt[bus.waddr1]     = 1'b0;
      if (alloc) busy_nxt[bus.alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Port 1 is the younger instruction, so its write is ordered after
  // port 0; the trap capture of PC comes last and overrides both.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
      busy <= '0;
    end else begin
      if (wr0)  rf[bus.waddr0] <= bus.wdata0;
      if (wr1)  rf[bus.waddr1] <= bus.wdata1;
      if (trap) rf[EPC_A]      <= bus.PC;
      busy <= busy_nxt;
    end
  end

  // Read ports. With forwarding, an in-flight write (including the trap
  // capture into EPC) supplies the data and therefore also hides the
  // busy bit, since the consumer no longer needs to wait for it.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int k = 0; k < NUM_READ; k++) begin : rd_port
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] d;
      logic              wr_hit;
      ra     = bus.raddr[k*ADDR_W +: ADDR_W];
      d      = rf[ra];
      wr_hit = 1'b0;
      if (FWD_EN != 0) begin
        wr_hit = (trap && (ra == EPC_A)) ||
                 (bus.we1 && (bus.waddr1 == ra)) ||
                 (bus.we0 && (bus.waddr0 == ra));
        if (trap && (ra == EPC_A))             d = bus.PC;
        else if (bus.we1 && (bus.waddr1 == ra)) d = bus.wdata1;
        else if (bus.we0 && (bus.waddr0 == ra)) d = bus.wdata0;
      end
      if (ra == '0) begin
        d      = '0;
        wr_hit = 1'b1;
      end
      rdata_c[k*DATA_W +: DATA_W] = d;
      rbusy_c[k]                  = busy[ra] && !wr_hit;
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.busy_vec = busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (bypass on / off) driven with identical
// stimulus, checked every cycle against a behavioural register-file model,
// plus directed scenarios with literal expectations.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic reset;
  logic interrupt, exception;
  logic [DW-1:0]    PC;
  logic [NR*AW-1:0] raddr;
  logic             we0, we1, alloc_en;
  logic [AW-1:0]    waddr0, waddr1, alloc_addr;
  logic [DW-1:0]    wdata0, wdata1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus1 ();
  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) bus0 ();

  assign bus1.interrupt = interrupt;   assign bus0.interrupt = interrupt;
  assign bus1.exception = exception;   assign bus0.exception = exception;
  assign bus1.PC = PC;                 assign bus0.PC = PC;
  assign bus1.raddr = raddr;           assign bus0.raddr = raddr;
  assign bus1.we0 = we0;               assign bus0.we0 = we0;
  assign bus1.waddr0 = waddr0;         assign bus0.waddr0 = waddr0;
  assign bus1.wdata0 = wdata0;         assign bus0.wdata0 = wdata0;
  assign bus1.we1 = we1;               assign bus0.we1 = we1;
  assign bus1.waddr1 = waddr1;         assign bus0.waddr1 = waddr1;
  assign bus1.wdata1 = wdata1;         assign bus0.wdata1 = wdata1;
  assign bus1.alloc_en = alloc_en;     assign bus0.alloc_en = alloc_en;
  assign bus1.alloc_addr = alloc_addr; assign bus0.alloc_addr = alloc_addr;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .FWD_EN(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .FWD_EN(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_rf [32];
  logic [31:0]   m_busy;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_rf[29] = 32'h0000_0800;
      m_busy   = '0;
    end else begin
      if (we0 && waddr0 != 0) m_rf[waddr0] = wdata0;
      if (we1 && waddr1 != 0) m_rf[waddr1] = wdata1;
      if (interrupt || exception) begin
        m_rf[26] = PC;
        m_busy   = '0;
      end else begin
        if (we0 && waddr0 != 0) m_busy[waddr0] = 1'b0;
        if (we1 && waddr1 != 0) m_busy[waddr1] = 1'b0;
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] m_read(input bit fwd, input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (fwd) begin
      if ((interrupt || exception) && a == 26) return PC;
      if (we1 && waddr1 == a) return wdata1;
      if (we0 && waddr0 == a) return wdata0;
    end
    return m_rf[a];
  endfunction

  function automatic logic m_rbusy(input bit fwd, input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (fwd && (((interrupt || exception) && a == 26) ||
                (we1 && waddr1 == a) || (we0 && waddr0 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      for (int k = 0; k < NR; k++) begin
        logic [AW-1:0] a;
        a = raddr[k*AW +: AW];
        chk($sformatf("rdata%0d_fwd1_r%0d", k, a), 64'(bus1.rdata[k*DW +: DW]), 64'(m_read(1'b1, a)));
        chk($sformatf("rdata%0d_fwd0_r%0d", k, a), 64'(bus0.rdata[k*DW +: DW]), 64'(m_read(1'b0, a)));
        chk($sformatf("rbusy%0d_fwd1_r%0d", k, a), 64'(bus1.rbusy[k]), 64'(m_rbusy(1'b1, a)));
        chk($sformatf("rbusy%0d_fwd0_r%0d", k, a), 64'(bus0.rbusy[k]), 64'(m_rbusy(1'b0, a)));
      end
      chk("busy_vec_fwd1", 64'(bus1.busy_vec), 64'(m_busy));
      chk("busy_vec_fwd0", 64'(bus0.busy_vec), 64'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset = 0; interrupt = 0; exception = 0; PC = '0; raddr = '0;
    we0 = 0; waddr0 = '0; wdata0 = '0;
    we1 = 0; waddr1 = '0; wdata1 = '0;
    alloc_en = 0; alloc_addr = '0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return 5'd0;
      1:       return 5'd26;
      2:       return 5'd29;
      3:       return 5'd5;
      default: return AW'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    reset = 1; interrupt = 0; exception = 0; PC = '0; raddr = '0;
    we0 = 0; waddr0 = '0; wdata0 = '0;
    we1 = 0; waddr1 = '0; wdata1 = '0;
    alloc_en = 0; alloc_addr = '0;

    // Reset state
    next_cycle();
    chk_en = 1;
    raddr = {5'd5, 5'd29};
    settle();
    chk("reset_sp", 64'(bus1.rdata[31:0]), 64'h800);
    chk("reset_r5", 64'(bus1.rdata[63:32]), 64'h0);
    chk("reset_busy", 64'(bus1.busy_vec), 64'h0);

    // Dual write to the same address: port 1 wins; r0 writes discarded
    next_cycle();
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hAAAA;
    we1 = 1; waddr1 = 5'd3; wdata1 = 32'h5555;
    next_cycle();
    raddr = {5'd0, 5'd3};
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    settle();
    chk("dual_r3", 64'(bus0.rdata[31:0]), 64'h5555);
    chk("r0_during_write", 64'(bus1.rdata[63:32]), 64'h0);
    next_cycle();
    raddr = {5'd0, 5'd0};
    settle();
    chk("r0_after_write", 64'(bus0.rdata[31:0]), 64'h0);

    // Bypass on vs off
    next_cycle();
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h1234;
    raddr = {5'd0, 5'd7};
    settle();
    chk("bypass_fwd1", 64'(bus1.rdata[31:0]), 64'h1234);
    chk("bypass_fwd0_old", 64'(bus0.rdata[31:0]), 64'h0);
    next_cycle();
    raddr = {5'd0, 5'd7};
    settle();
    chk("bypass_fwd0_next", 64'(bus0.rdata[31:0]), 64'h1234);

    // Trap: EPC capture overrides port write, other write commits, flush
    next_cycle();
    alloc_en = 1; alloc_addr = 5'd9;
    next_cycle();
    we0 = 1; waddr0 = 5'd26; wdata0 = 32'h99;
    we1 = 1; waddr1 = 5'd4;  wdata1 = 32'h44;
    exception = 1; PC = 32'h400;
    raddr = {5'd0, 5'd26};
    settle();
    chk("busy9_before_trap", 64'(bus1.busy_vec[9]), 64'h1);
    chk("trap_bypass_pc", 64'(bus1.rdata[31:0]), 64'h400);
    next_cycle();
    raddr = {5'd4, 5'd26};
    settle();
    chk("trap_epc", 64'(bus0.rdata[31:0]), 64'h400);
    chk("trap_r4", 64'(bus0.rdata[63:32]), 64'h44);
    chk("trap_flush", 64'(bus1.busy_vec), 64'h0);

    // Scoreboard
    next_cycle();
    alloc_en = 1; alloc_addr = 5'd5;
    next_cycle();
    raddr = {5'd0, 5'd5};
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hAB;
    alloc_en = 1; alloc_addr = 5'd5;
    settle();
    chk("alloc_visible_fwd0", 64'(bus0.rbusy[0]), 64'h1);
    chk("alloc_masked_fwd1", 64'(bus1.rbusy[0]), 64'h0);
    next_cycle();
    raddr = {5'd0, 5'd5};
    settle();
    chk("set_beats_clear", 64'(bus1.rbusy[0]), 64'h1);
    next_cycle();
    we1 = 1; waddr1 = 5'd5; wdata1 = 32'hCD;
    raddr = {5'd0, 5'd5};
    settle();
    chk("wr_masks_rbusy_fwd1", 64'(bus1.rbusy[0]), 64'h0);
    chk("wr_no_mask_fwd0", 64'(bus0.rbusy[0]), 64'h1);
    next_cycle();
    raddr = {5'd0, 5'd5};
    settle();
    chk("busy_cleared", 64'(bus0.rbusy[0]), 64'h0);

    // Mid-operation reset
    next_cycle();
    we0 = 1; waddr0 = 5'd6; wdata0 = 32'h55;
    alloc_en = 1; alloc_addr = 5'd6;
    next_cycle();
    settle();
    chk("busy6_before_reset", 64'(bus1.busy_vec[6]), 64'h1);
    reset = 1;
    we0 = 1; waddr0 = 5'd6; wdata0 = 32'h77;
    alloc_en = 1; alloc_addr = 5'd6;
    next_cycle();
    raddr = {5'd29, 5'd6};
    settle();
    chk("midreset_r6", 64'(bus0.rdata[31:0]), 64'h0);
    chk("midreset_sp", 64'(bus0.rdata[63:32]), 64'h800);
    chk("midreset_busy", 64'(bus1.busy_vec), 64'h0);

    // Randomised traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset      = ($urandom_range(0, 99) == 0);
      interrupt  = ($urandom_range(0, 19) == 0);
      exception  = ($urandom_range(0, 19) == 0);
      PC         = $urandom;
      raddr      = {pick_addr(), pick_addr()};
      we0        = $urandom_range(0, 1) == 1;
      waddr0     = pick_addr();
      wdata0     = $urandom;
      we1        = $urandom_range(0, 1) == 1;
      waddr1     = pick_addr();
      wdata1     = $urandom;
      alloc_en   = $urandom_range(0, 2) != 0;
      alloc_addr = pick_addr();
    end

    next_cycle();
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file for the pipelined CPU: NUM_READ combinational read ports, two write ports, and a per-register busy scoreboard.
- Register 0 is hardwired to zero; the stack-pointer register has a programmable reset value.
- On interrupt or exception, the PC is captured into the EPC link register, and all scoreboard entries are flushed.
- Sits between decode (reads, destination allocation) and writeback (commits).

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_READ, 2, number of read ports (1..4).
- SP_INDEX, 29, register that resets to SP_RESET.
- SP_RESET, 32'h00000800, stack-pointer reset value.
- EPC_INDEX, 26, register that receives PC on a trap.
- FWD_EN, 1, 1 = write-through bypass on reads; 0 = reads return array contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- interrupt  in  1  trap request (interrupt).
- exception  in  1  trap request (exception).
- PC  in  DATA_W  value captured into EPC_INDEX on a trap.
- raddr  in  NUM_READ*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_READ*DATA_W  read data, packed the same way as raddr.
- rbusy  out  NUM_READ  per-port scoreboard hit.
- we0, waddr0, wdata0  in  1/ADDR_W/DATA_W  write port 0.
- we1, waddr1, wdata1  in  1/ADDR_W/DATA_W  write port 1 (younger instruction).
- alloc_en, alloc_addr  in  1/ADDR_W  mark destination register busy.
- busy_vec  out  DEPTH  raw scoreboard state; bit 0 is always 0.

Behaviour:
- Reset: on the clk edge with reset=1:
  - all registers 1..DEPTH-1 are set to 0, except SP_INDEX, which is set to SP_RESET;
  - busy_vec = 0;
  - all other inputs are ignored that cycle.
- Reset is checked before trap handling, so reset asserted mid-operation wins over everything.
- Outputs: rdata and rbusy are combinational, so their values follow from the reset state.
- Register 0: reads always return 0; writes are discarded; it is never marked busy.
- Writes (registered, 1-cycle latency into the array):
  - a write takes effect when weN=1 and waddrN!=0;
  - if both ports write the same address, port 1 wins;
  - writes to different addresses both commit.
- Trap (trap = interrupt | exception), evaluated when reset=0:
  - RF[EPC_INDEX] <= PC; this overrides any port write to EPC_INDEX in the same cycle;
  - writes to other addresses still commit;
  - busy_vec is cleared to 0 and alloc_en is ignored that cycle;
  - interrupt and exception together behave the same as a single trap.
- Read port k:
  - raddr=0 returns 0;
  - otherwise, with FWD_EN=1, the first matching source wins:
    1. trap && raddr==EPC_INDEX returns PC;
    2. we1 && waddr1==raddr returns wdata1;
    3. we0 && waddr0==raddr returns wdata0;
    4. the array entry;
  - with FWD_EN=0, reads return the array entry only.
- Scoreboard (when no trap):
  - busy[a] is cleared when a write port commits to a;
  - busy[alloc_addr] is set when alloc_en=1 and alloc_addr!=0;
  - set beats clear on the same address in the same cycle (a new producer supersedes the old one).
- rbusy[k] = busy[raddr_k], masked to 0 when:
  - raddr_k = 0, or
  - FWD_EN=1 and a write to raddr_k is occurring this cycle (the bypass supplies the data).
- No combinational path from alloc_* to rbusy; allocation is visible from the next cycle.

Test Plan:
- Reset: assert reset for 1 cycle, then read reg 29 and reg 5 -> 32'h00000800 and 0; busy_vec = 0.
- Dual write: we0 to r3 = 0xAAAA and we1 to r3 = 0x5555 in the same cycle -> next-cycle read r3 = 0x5555. Write to r0 = 0xFFFF -> r0 reads 0.
- Bypass: we0 r7 = 0x1234 with raddr r7 in the same cycle -> rdata = 0x1234 that cycle (FWD_EN=1). Repeat with FWD_EN=0 -> old value 0 that cycle, 0x1234 the next cycle.
- Trap:
  - Setup: we0 r26 = 0x99 and we1 r4 = 0x44 with exception=1, PC = 0x400 -> r26 = 0x400, r4 = 0x44.
  - Flush: alloc r9 in the prior cycle gives busy[9] = 1; after the trap, busy_vec = 0.
- Scoreboard:
  - alloc r5 -> next cycle rbusy = 1 for raddr r5;
  - we0 r5 in the same cycle as alloc r5 -> busy stays 1;
  - we1 r5 alone -> rbusy = 0 during the write cycle and after it.
- Mid-operation reset: alloc r6 and we0 r6 = 0x77 with reset=1 -> r6 = 0, busy[6] = 0.
